// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ILEN = 32;

    // One prefetch queue entry: instruction word tagged with its PC.
    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t FETCH_ENTRY_RST = '{pc: '0, instr: '0};

    // Clear the byte offset so every fetch address is word-aligned.
    function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
        return addr & ~ILEN'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory, redirect and decode-side handshake bundle of the fetch stage.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [ILEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [ILEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instruction;
    logic [ILEN-1:0] out_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instruction, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instruction, out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and a registered head.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  head_q, head_d;
    logic          head_valid_q, head_valid_d;
    logic          do_push, do_pop;

    // Pointer/count update; head is precomputed so it leaves a flop.
    always_comb begin
        do_push      = push && (count_q != CW'(DEPTH));
        do_pop       = pop && (count_q != '0);
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
        head_valid_d = (count_d != '0);
        head_d       = head_valid_d ? mem_d[rd_ptr_d] : FETCH_ENTRY_RST;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= FETCH_ENTRY_RST;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head       = head_q;
    assign head_valid = head_valid_q;
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited prefetch from in-order memory with redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ILEN-1:0] initial_pc,
    fetch_unit_if.master    bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [ILEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   occupancy, tag_count;
    logic [SW-1:0]   credit_used;
    logic            issue, resp_keep, out_fire;
    logic            q_valid, tag_valid, unused_tag;
    fetch_entry_t    tag_head, out_head, tag_push_data, q_push_data;

    // Issue/accept/pop qualifiers; redirect and reset override everything.
    always_comb begin
        credit_used   = SW'(outstanding_q) + SW'(occupancy);
        issue         = reset && !bus.redirect_valid && (drop_cnt_q == '0)
                        && (credit_used < SW'(DEPTH));
        resp_keep     = reset && !bus.redirect_valid && bus.imem_rvalid && (drop_cnt_q == '0);
        out_fire      = reset && !bus.redirect_valid && q_valid && bus.out_ready;
        tag_push_data = '{pc: fetch_pc_q, instr: '0};
        q_push_data   = '{pc: tag_head.pc, instr: bus.imem_rdata};
    end

    // Next fetch PC, in-flight count and count of responses still to discard.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (bus.redirect_valid) begin
            fetch_pc_d    = word_align(bus.redirect_pc);
            outstanding_d = outstanding_q - CW'(bus.imem_rvalid);
            drop_cnt_d    = outstanding_q - CW'(bus.imem_rvalid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ILEN'(4);
            end
            outstanding_d = outstanding_q + CW'(issue) - CW'(bus.imem_rvalid);
            if (bus.imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // Fetch state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q    <= word_align(initial_pc);
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // PCs of requests still awaiting a response, in issue order.
    fetch_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (bus.redirect_valid),
        .push       (issue),
        .push_data  (tag_push_data),
        .pop        (resp_keep),
        .head       (tag_head),
        .head_valid (tag_valid),
        .count      (tag_count)
    );

    // Returned instructions waiting for decode.
    fetch_fifo #(.DEPTH(DEPTH)) u_inst_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (bus.redirect_valid),
        .push       (resp_keep),
        .push_data  (q_push_data),
        .pop        (out_fire),
        .head       (out_head),
        .head_valid (q_valid),
        .count      (occupancy)
    );

    assign unused_tag          = ^{tag_head.instr, tag_count, tag_valid};

    assign bus.imem_req        = issue;
    assign bus.imem_addr       = word_align(fetch_pc_q);
    assign bus.out_valid       = q_valid;
    assign bus.out_instruction = out_head.instr;
    assign bus.out_pc          = out_head.pc;

endmodule
